// File: rtl/sram_axi_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_axi_arbiter_pkg
// Shared definitions for the SRAM-like to AXI3 bridge:
//   - read / write FSM state encodings (also exported on debug ports)
//   - default AXI IDs for instruction and data traffic
//   - SRAM size codes and the fixed single-beat AXI burst constants
//   - axi_size(): maps a 2-bit SRAM size code onto the 3-bit AXI size field
// -----------------------------------------------------------------------------
package sram_axi_arbiter_pkg;

    localparam int         ADDR_W_DEF     = 32;
    localparam int         DATA_W_DEF     = 32;

    localparam logic [3:0] INST_ID_DEF    = 4'd0;
    localparam logic [3:0] DATA_ID_DEF    = 4'd1;

    localparam logic [1:0] SIZE_BYTE      = 2'd0;
    localparam logic [1:0] SIZE_HALF      = 2'd1;
    localparam logic [1:0] SIZE_WORD      = 2'd2;

    // Every transfer is a single INCR beat; these are tied off at the crossbar.
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW   = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_axi_arbiter_if
// Bundles the two CPU SRAM-like ports (inst_*, data_*) and the reduced AXI3
// master channel set (AR/R/AW/W/B) used by sram_axi_arbiter.
//   modport master : the arbiter's view (AXI master, SRAM-like slave)
//   modport slave  : the environment's view (CPU pipeline + AXI crossbar)
// Handshake rule on every AXI channel: a beat transfers on the rising edge
// where valid && ready are both high; valid, once raised, stays high with
// stable payload until that edge. addr_ok/data_ok are single-cycle pulses.
// -----------------------------------------------------------------------------
interface sram_axi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // instruction SRAM-like port
    logic              inst_req;
    logic              inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    // data SRAM-like port
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    // AXI3 channels
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awsize;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;

    modport master (
        input  inst_req, inst_wr, inst_size, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output arid, araddr, arsize, arvalid,
        input  arready,
        input  rid, rdata, rvalid,
        output rready,
        output awaddr, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        output inst_req, inst_wr, inst_size, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  arid, araddr, arsize, arvalid,
        output arready,
        output rid, rdata, rvalid,
        input  rready,
        input  awaddr, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_wr_ctrl.sv
// -----------------------------------------------------------------------------
// sram_axi_wr_ctrl
// Write sequencer for data-port stores: accepts one write, drives AW and W
// together (each dropping after its own handshake), then waits for B.
// Configuration macro: SRAM_AXI_EARLY_WACK_EN
//   defined   : ack_o pulses in the cycle AW and W are both complete
//   undefined : ack_o pulses on the B handshake
// Either way no new write is accepted and pending_o stays high until B.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wr_req_i              data_req && data_wr from the CPU
//   addr_i/size_i/wstrb_i/wdata_i   write request payload
//   addr_ok_o             request accepted (single-cycle pulse)
//   ack_o                 write completion pulse for data_data_ok
//   pending_o             a write is outstanding (acceptance .. B handshake)
//   aw*/w*/b*             AXI write channels
//   state_o               FSM state for debug/observation
// -----------------------------------------------------------------------------
module sram_axi_wr_ctrl
    import sram_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_req_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [1:0]          size_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                addr_ok_o,
    output logic                ack_o,
    output logic                pending_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [2:0]          awsize_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    output wr_state_e           state_o
);

    wr_state_e           state_q, state_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                latch_en;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [DATA_W-1:0]   wdata_q;

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        latch_en  = 1'b0;
        addr_ok_o = 1'b0;
        ack_o     = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (wr_req_i) begin
                    addr_ok_o = 1'b1;
                    latch_en  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = W_AW;
                end
            end
            W_AW: begin
                awvalid_o = !aw_done_q;
                wvalid_o  = !w_done_q;
                if (!aw_done_q && awready_i) aw_done_d = 1'b1;
                if (!w_done_q && wready_i)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = W_B;
`ifdef SRAM_AXI_EARLY_WACK_EN
                    ack_o   = 1'b1;
`endif
                end
            end
            W_B: begin
                bready_o = 1'b1;
                if (bvalid_i) begin
                    state_d = W_IDLE;
`ifdef SRAM_AXI_EARLY_WACK_EN
`else
                    ack_o   = 1'b1;
`endif
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (latch_en) begin
                addr_q  <= addr_i;
                size_q  <= size_i;
                wstrb_q <= wstrb_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign pending_o = (state_q != W_IDLE);
    assign awaddr_o  = addr_q;
    assign awsize_o  = axi_size(size_q);
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign state_o   = state_q;

endmodule

// File: rtl/sram_axi_arbiter.sv
// -----------------------------------------------------------------------------
// sram_axi_arbiter
// Shares one AXI3 master port between the CPU instruction-fetch and data
// SRAM-like ports. Reads go through a single AR/R sequencer (data reads have
// fixed priority over instruction reads); data writes go through
// sram_axi_wr_ctrl and may overlap a read unless the read hits the word the
// pending write targets.
// Configuration macro: SRAM_AXI_EARLY_WACK_EN (see sram_axi_wr_ctrl).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus            sram_axi_arbiter_if.master: inst_*, data_*, AXI AR/R/AW/W/B
//   rd_state_o     read FSM state (debug)
//   wr_state_o     write FSM state (debug)
// -----------------------------------------------------------------------------
module sram_axi_arbiter
    import sram_axi_arbiter_pkg::*;
#(
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter int         DATA_W  = DATA_W_DEF,
    parameter logic [3:0] INST_ID = INST_ID_DEF,
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic               clk,
    input  logic               reset,
    sram_axi_arbiter_if.master bus,
    output rd_state_e          rd_state_o,
    output wr_state_e          wr_state_o
);

    rd_state_e         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]        rd_size_q, rd_size_d;
    logic [3:0]        rd_id_q, rd_id_d;
    logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

    logic inst_rd_ok, data_rd_ok, data_rd_aok;
    logic wr_aok, wr_ack, wr_pending;
    logic hazard, data_rd_elig, rd_collide;

    // The instruction port never writes; its wr flag is intentionally ignored.
    logic unused_inst_wr;
    assign unused_inst_wr = bus.inst_wr;

    // A data read aimed at the word an outstanding write targets must wait
    // until that write's B response, so it cannot return stale memory.
    assign hazard       = wr_pending && (bus.awaddr[ADDR_W-1:2] == bus.data_addr[ADDR_W-1:2]);
    assign data_rd_elig = bus.data_req && !bus.data_wr && !hazard;

    // If a write completion and a data-port read return would land in the same
    // cycle they would merge into one data_data_ok pulse; hold off the R beat.
    assign rd_collide = wr_ack && (bus.rid == DATA_ID);

    always_comb begin
        rd_state_d       = rd_state_q;
        rd_addr_d        = rd_addr_q;
        rd_size_d        = rd_size_q;
        rd_id_d          = rd_id_q;
        bus.inst_addr_ok = 1'b0;
        data_rd_aok      = 1'b0;
        inst_rd_ok       = 1'b0;
        data_rd_ok       = 1'b0;
        bus.rready       = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (data_rd_elig) begin
                    data_rd_aok = 1'b1;
                    rd_addr_d   = bus.data_addr;
                    rd_size_d   = bus.data_size;
                    rd_id_d     = DATA_ID;
                    rd_state_d  = R_AR;
                end else if (bus.inst_req) begin
                    bus.inst_addr_ok = 1'b1;
                    rd_addr_d        = bus.inst_addr;
                    rd_size_d        = bus.inst_size;
                    rd_id_d          = INST_ID;
                    rd_state_d       = R_AR;
                end
            end
            R_AR: begin
                if (bus.arready) rd_state_d = R_R;
            end
            R_R: begin
                bus.rready = !rd_collide;
                if (bus.rvalid && !rd_collide) begin
                    inst_rd_ok = (bus.rid == INST_ID);
                    data_rd_ok = (bus.rid == DATA_ID);
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q   <= R_IDLE;
            rd_addr_q    <= '0;
            rd_size_q    <= '0;
            rd_id_q      <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_size_q  <= rd_size_d;
            rd_id_q    <= rd_id_d;
            if (inst_rd_ok) inst_rdata_q <= bus.rdata;
            if (data_rd_ok) data_rdata_q <= bus.rdata;
        end
    end

    assign bus.arvalid = (rd_state_q == R_AR);
    assign bus.araddr  = rd_addr_q;
    assign bus.arsize  = axi_size(rd_size_q);
    assign bus.arid    = rd_id_q;

    // Read data is forwarded combinationally in the data_ok cycle, held after.
    assign bus.inst_data_ok = inst_rd_ok;
    assign bus.inst_rdata   = inst_rd_ok ? bus.rdata : inst_rdata_q;
    assign bus.data_rdata   = data_rd_ok ? bus.rdata : data_rdata_q;

    // Reads and writes on the data port are mutually exclusive per cycle
    // (selected by data_wr), so at most one of the two accepts.
    assign bus.data_addr_ok = data_rd_aok | wr_aok;
    assign bus.data_data_ok = data_rd_ok | wr_ack;

    sram_axi_wr_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_ctrl (
        .clk       (clk),
        .reset     (reset),
        .wr_req_i  (bus.data_req && bus.data_wr),
        .addr_i    (bus.data_addr),
        .size_i    (bus.data_size),
        .wstrb_i   (bus.data_wstrb),
        .wdata_i   (bus.data_wdata),
        .addr_ok_o (wr_aok),
        .ack_o     (wr_ack),
        .pending_o (wr_pending),
        .awaddr_o  (bus.awaddr),
        .awsize_o  (bus.awsize),
        .awvalid_o (bus.awvalid),
        .awready_i (bus.awready),
        .wdata_o   (bus.wdata),
        .wstrb_o   (bus.wstrb),
        .wvalid_o  (bus.wvalid),
        .wready_i  (bus.wready),
        .bvalid_i  (bus.bvalid),
        .bready_o  (bus.bready),
        .state_o   (wr_state_o)
    );

    assign rd_state_o = rd_state_q;

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_axi_arbiter
// Directed bench for sram_axi_arbiter: instruction read, data-over-inst
// priority, write with skewed AW/W readies and a delayed B, same-word read
// hazard, non-hazard overlap, and reset in the middle of a transaction.
// Expected write-ack timing follows SRAM_AXI_EARLY_WACK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_sram_axi_arbiter;
    import sram_axi_arbiter_pkg::*;

    logic      clk;
    logic      reset;
    rd_state_e rd_state;
    wr_state_e wr_state;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

`ifdef SRAM_AXI_EARLY_WACK_EN
    localparam logic EARLY = 1'b1;
`else
    localparam logic EARLY = 1'b0;
`endif

    sram_axi_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    sram_axi_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .rd_state_o (rd_state),
        .wr_state_o (wr_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 0; bus.inst_addr = 0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
        bus.data_addr = 0; bus.data_wdata = 0;
        bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rvalid = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
    endtask

    // Hold arready low for 'delay' cycles, then accept the AR beat.
    task automatic ar_accept(input string tag, input logic [3:0] id, input logic [31:0] addr,
                             input int delay);
        for (int i = 0; i < delay; i++) begin
            #1; check({tag, "_arvalid_wait"}, bus.arvalid, 1);
            step();
        end
        bus.arready = 1; #1;
        check({tag, "_arvalid"}, bus.arvalid, 1);
        check({tag, "_arid"}, bus.arid, id);
        check({tag, "_araddr"}, bus.araddr, addr);
        step();
        bus.arready = 0;
    endtask

    // Return one R beat; expected read data comes from the scoreboard queue.
    task automatic r_return(input string tag, input logic [3:0] id, input logic [31:0] data);
        logic [31:0] exp;
        #1; check({tag, "_rready"}, bus.rready, 1);
        bus.rvalid = 1; bus.rid = id; bus.rdata = data; #1;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check({tag, "_inst_dok"}, bus.inst_data_ok, id == 4'd0);
        check({tag, "_data_dok"}, bus.data_data_ok, id == 4'd1);
        check({tag, "_rdata"}, (id == 4'd0) ? bus.inst_rdata : bus.data_rdata, exp);
        step();
        bus.rvalid = 0; #1;
        check({tag, "_dok_pulse"}, {bus.inst_data_ok, bus.data_data_ok}, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        drive_idle();
        reset = 1;
        step(); step();
        check("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 0);
        check("rst_oks", {bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok}, 0);
        check("rst_states", {30'd0, rd_state == R_IDLE, wr_state == W_IDLE}, 32'd3);
        reset = 0;

        // 1: instruction read, arready after 2 cycles
        bus.inst_req = 1; bus.inst_size = 2; bus.inst_addr = 32'hbfc0_0000; #1;
        check("t1_inst_aok", bus.inst_addr_ok, 1);
        check("t1_data_aok", bus.data_addr_ok, 0);
        exp_q.push_back(32'h3c08_0001);
        step(); bus.inst_req = 0; #1;
        check("t1_arsize", bus.arsize, 3'd2);
        ar_accept("t1", 4'd0, 32'hbfc0_0000, 2);
        r_return("t1", 4'd0, 32'h3c08_0001);
        check("t1_hold", bus.inst_rdata, 32'h3c08_0001);

        // 2: simultaneous inst and data read, data wins
        bus.inst_req = 1; bus.inst_addr = 32'hbfc0_0004;
        bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2; bus.data_addr = 32'h8000_1000; #1;
        check("t2_data_aok", bus.data_addr_ok, 1);
        check("t2_inst_aok", bus.inst_addr_ok, 0);
        exp_q.push_back(32'h1234_5678);
        step(); bus.data_req = 0; #1;
        check("t2_inst_blk_ar", bus.inst_addr_ok, 0);
        ar_accept("t2d", 4'd1, 32'h8000_1000, 0);
        #1; check("t2_inst_blk_r", bus.inst_addr_ok, 0);
        r_return("t2d", 4'd1, 32'h1234_5678);
        check("t2_inst_aok_late", bus.inst_addr_ok, 1);
        exp_q.push_back(32'h27bd_fff8);
        step(); bus.inst_req = 0;
        ar_accept("t2i", 4'd0, 32'hbfc0_0004, 1);
        r_return("t2i", 4'd0, 32'h27bd_fff8);
        check("t2_drdata_hold", bus.data_rdata, 32'h1234_5678);

        // 3: write, awready 3 cycles ahead of wready, B delayed 5 cycles
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h8000_2000; bus.data_size = 2;
        bus.data_wstrb = 4'hf; bus.data_wdata = 32'hdead_beef; #1;
        check("t3_aok", bus.data_addr_ok, 1);
        step(); bus.data_req = 0; bus.data_wr = 0; #1;
        check("t3_valids", {bus.awvalid, bus.wvalid}, 2'b11);
        check("t3_awaddr", bus.awaddr, 32'h8000_2000);
        check("t3_awsize", bus.awsize, 3'd2);
        check("t3_wdata", bus.wdata, 32'hdead_beef);
        check("t3_wstrb", bus.wstrb, 4'hf);
        bus.awready = 1; #1;
        check("t3_aw_no_ack", bus.data_data_ok, 0);
        step(); bus.awready = 0; #1;
        check("t3_aw_drop", {bus.awvalid, bus.wvalid}, 2'b01);
        step(); #1;
        check("t3_w_hold", bus.wvalid, 1);
        step(); bus.wready = 1; #1;
        check("t3_w_hs", bus.wvalid, 1);
        check("t3_early_ack", bus.data_data_ok, EARLY);
        step(); bus.wready = 0;
        // second write requested while the first waits for B
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h8000_2004; bus.data_size = 1;
        bus.data_wstrb = 4'h3; bus.data_wdata = 32'hcafe_f00d;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_wb_bready", bus.bready, 1);
            check("t3_wb_wvalid", bus.wvalid, 0);
            check("t3_wb_blocked", bus.data_addr_ok, 0);
            check("t3_wb_no_ack", bus.data_data_ok, 0);
            step();
        end
        bus.bvalid = 1; #1;
        check("t3_b_ack", bus.data_data_ok, !EARLY);
        check("t3_b_blocked", bus.data_addr_ok, 0);
        step(); bus.bvalid = 0; #1;
        check("t3_next_aok", bus.data_addr_ok, 1);
        step(); bus.data_req = 0; bus.data_wr = 0;

        // 4: read to the pending write's word is held off until B
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h8000_2004; bus.data_size = 2; #1;
        check("t4_hz_aw", bus.data_addr_ok, 0);
        check("t4_awaddr", bus.awaddr, 32'h8000_2004);
        check("t4_awsize", bus.awsize, 3'd1);
        check("t4_wstrb", bus.wstrb, 4'h3);
        bus.awready = 1; bus.wready = 1; #1;
        check("t4_early_ack", bus.data_data_ok, EARLY);
        check("t4_hz_hs", bus.data_addr_ok, 0);
        step(); bus.awready = 0; bus.wready = 0; #1;
        check("t4_hz_b", bus.data_addr_ok, 0);
        bus.bvalid = 1; #1;
        check("t4_b_ack", bus.data_data_ok, !EARLY);
        check("t4_hz_bhs", bus.data_addr_ok, 0);
        step(); bus.bvalid = 0; #1;
        check("t4_release", bus.data_addr_ok, 1);
        exp_q.push_back(32'h0000_f00d);
        step(); bus.data_req = 0;
        ar_accept("t4r", 4'd1, 32'h8000_2004, 0);
        r_return("t4r", 4'd1, 32'h0000_f00d);

        // 4b: different word is accepted while the write is pending
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h8000_2004; bus.data_size = 2;
        bus.data_wstrb = 4'hf; bus.data_wdata = 32'h1111_1111; #1;
        check("t4b_w_aok", bus.data_addr_ok, 1);
        step(); bus.data_wr = 0; bus.data_addr = 32'h8000_3000; #1;
        check("t4b_rd_aok", bus.data_addr_ok, 1);
        exp_q.push_back(32'ha5a5_a5a5);
        step(); bus.data_req = 0;
        ar_accept("t4b", 4'd1, 32'h8000_3000, 0);
        r_return("t4b", 4'd1, 32'ha5a5_a5a5);
        bus.awready = 1; bus.wready = 1; #1;
        check("t4b_early_ack", bus.data_data_ok, EARLY);
        step(); bus.awready = 0; bus.wready = 0; bus.bvalid = 1; #1;
        check("t4b_b_ack", bus.data_data_ok, !EARLY);
        step(); bus.bvalid = 0; #1;
        check("t4b_wr_idle", {30'd0, wr_state}, 32'(W_IDLE));

        // 5: reset while AR and AW/W are in flight
        bus.inst_req = 1; bus.inst_addr = 32'hbfc0_0100;
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h8000_4000; #1;
        check("t5_aoks", {bus.inst_addr_ok, bus.data_addr_ok}, 2'b11);
        step(); bus.inst_req = 0; bus.data_req = 0; bus.data_wr = 0; #1;
        check("t5_inflight", {bus.arvalid, bus.awvalid}, 2'b11);
        reset = 1; bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h5555_aaaa; #1;
        check("t5_rst_no_dok", {bus.inst_data_ok, bus.data_data_ok}, 0);
        step(); reset = 0; bus.rvalid = 0; #1;
        check("t5_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready}, 0);
        check("t5_doks", {bus.inst_data_ok, bus.data_data_ok}, 0);
        check("t5_rdata", {bus.inst_rdata, bus.data_rdata} == 64'd0, 1);
        check("t5_rd_state", {30'd0, rd_state}, 32'(R_IDLE));
        check("t5_wr_state", {30'd0, wr_state}, 32'(W_IDLE));
        step(); #1;
        check("t5_quiet", {bus.inst_data_ok, bus.data_data_ok, bus.arvalid}, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
